// File: rtl/pl_inv_iter.sv
// pl_inv_iter
//
// Iterative inverse of the ASCON linear diffusion layer pl. Each pl word is
// multiplication by p = 1 + X^a + X^b modulo X^64 + 1. Since p^64 = 1, the
// inverse is p^63 = p^1 * p^2 * p^4 * p^8 * p^16 * p^32. Squaring in
// characteristic 2 gives p^(2^k) = 1 + X^(2^k*a) + X^(2^k*b), so every factor
// is a single rotate-XOR step. The block applies one step per clock over six
// clocks.
//
// Ports
//   clock_i   : system clock, rising-edge active
//   reset_i   : synchronous active-high reset, highest priority
//   start_i   : request an inversion, sampled only while idle
//   pl_inv_i  : 5x64 state to invert (a pl output), word i = pl_inv_i[i]
//   pl_inv_o  : 5x64 working/result state, final when valid_o = 1
//   valid_o   : one-cycle pulse when pl_inv_o has just been completed
//   busy_o    : high during the six step cycles
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start_i; result of the last inversion is held
// RUN   | applying step k (0..5) to all five words in parallel
// DONE  | result complete; valid_o is high for this one cycle

module pl_inv_iter (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [4:0][63:0] pl_inv_i,
    output logic [4:0][63:0] pl_inv_o,
    output logic             valid_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Base rotation pair of each pl word.
    localparam logic [5:0] ROT_A [5] = '{6'd19, 6'd61, 6'd1, 6'd10, 6'd7};
    localparam logic [5:0] ROT_B [5] = '{6'd28, 6'd39, 6'd6, 6'd17, 6'd41};

    state_e           state, state_next;
    logic [2:0]       k, k_next;
    logic [4:0][63:0] s, s_next;
    logic             valid_next, busy_next;

    // (2^step * base) mod 64: the 6-bit result drops the carried-out bits.
    // With constant bases this reduces to a small mux of constants on step.
    function automatic logic [5:0] rot_amount(input logic [5:0] base,
                                              input logic [2:0] step);
        logic [5:0] amt;
        amt = base << step;
        return amt;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x,
                                         input logic [5:0]  amt);
        logic [127:0] both;
        both = {x, x} >> amt;
        return both[63:0];
    endfunction

    always_comb begin
        state_next = state;
        k_next     = k;
        s_next     = s;
        case (state)
            IDLE: begin
                if (start_i) begin
                    s_next     = pl_inv_i;
                    k_next     = 3'd0;
                    state_next = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < 5; i++) begin
                    s_next[i] = s[i]
                              ^ rotr(s[i], rot_amount(ROT_A[i], k))
                              ^ rotr(s[i], rot_amount(ROT_B[i], k));
                end
                k_next = k + 3'd1;
                if (k == 3'd5) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                k_next     = 3'd0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next  = (state_next == RUN);
        valid_next = (state_next == DONE);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state   <= IDLE;
            k       <= 3'd0;
            s       <= '0;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            state   <= state_next;
            k       <= k_next;
            s       <= s_next;
            valid_o <= valid_next;
            busy_o  <= busy_next;
        end
    end

    assign pl_inv_o = s;

endmodule

// File: tb/tb_pl_inv_iter.sv
// Testbench for pl_inv_iter: directed and round-trip vectors through a
// forward pl model, with a queue-based scoreboard checked at valid_o.

module tb_pl_inv_iter;

    typedef logic [4:0][63:0] st_t;
    typedef struct {
        st_t exp_out;
        st_t inp;
    } item_t;

    logic clock_i;
    logic reset_i;
    logic start_i;
    st_t  pl_inv_i;
    st_t  pl_inv_o;
    logic valid_o;
    logic busy_o;

    int    checks = 0;
    int    errors = 0;
    int    nvalid = 0;
    item_t sb_q[$];

    pl_inv_iter dut (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .start_i  (start_i),
        .pl_inv_i (pl_inv_i),
        .pl_inv_o (pl_inv_o),
        .valid_o  (valid_o),
        .busy_o   (busy_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Forward ASCON linear layer.
    function automatic st_t pl(input st_t x);
        st_t r;
        r[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
        r[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
        r[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
        r[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
        r[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
        return r;
    endfunction

    function automatic st_t rand_state();
        st_t r;
        for (int i = 0; i < 5; i++) r[i] = {$urandom, $urandom};
        return r;
    endfunction

    task automatic chk(input string name, input logic [319:0] act,
                       input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every valid_o pulse pops one expected result.
    always @(negedge clock_i) begin
        if (valid_o) begin
            item_t it;
            nvalid++;
            chk("valid_busy_exclusive", 320'(busy_o), 320'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", 320'd1, 320'd0);
            end else begin
                it = sb_q.pop_front();
                chk("inverse_data", pl_inv_o, it.exp_out);
                chk("reverse_pl", pl(pl_inv_o), it.inp);
            end
        end
    end

    // One inversion with full timing checks; x is the expected result, y = pl(x).
    task automatic run_one(input st_t x, input st_t y);
        item_t it;
        @(negedge clock_i);
        start_i  = 1'b1;
        pl_inv_i = y;
        it.exp_out = x;
        it.inp     = y;
        sb_q.push_back(it);
        @(posedge clock_i); #1;
        start_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk("busy_during_run", 320'(busy_o), 320'd1);
            chk("no_valid_during_run", 320'(valid_o), 320'd0);
            @(posedge clock_i); #1;
        end
        chk("busy_low_at_done", 320'(busy_o), 320'd0);
        chk("valid_at_done", 320'(valid_o), 320'd1);
        @(posedge clock_i); #1;
        chk("valid_one_cycle", 320'(valid_o), 320'd0);
        chk("idle_not_busy", 320'(busy_o), 320'd0);
    endtask

    initial begin
        st_t x, y, ones, rt;
        int  busy_cnt, v0;

        reset_i  = 1'b1;
        start_i  = 1'b0;
        pl_inv_i = '0;
        repeat (3) @(posedge clock_i);
        #1;
        chk("reset_out", pl_inv_o, 320'd0);
        chk("reset_valid", 320'(valid_o), 320'd0);
        chk("reset_busy", 320'(busy_o), 320'd0);
        @(negedge clock_i);
        reset_i = 1'b0;

        // All zero and all ones are fixed points of pl.
        run_one('0, '0);
        for (int i = 0; i < 5; i++) ones[i] = 64'hFFFF_FFFF_FFFF_FFFF;
        run_one(ones, ones);

        // Directed round trip.
        rt[0] = 64'h8859263f4c5d6e8f;
        rt[1] = 64'h00c18e8584858607;
        rt[2] = 64'h7f7f7f7f7f7f7f8f;
        rt[3] = 64'h80c0848680808070;
        rt[4] = 64'h8888888a88888888;
        run_one(rt, pl(rt));

        // Random round trips.
        for (int n = 0; n < 100; n++) begin
            x = rand_state();
            run_one(x, pl(x));
        end

        // start_i held high: accepted at every 8th edge only.
        busy_cnt = 0;
        v0 = nvalid;
        @(negedge clock_i);
        start_i = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (busy_o) busy_cnt++;
            x = rand_state();
            pl_inv_i = pl(x);
            if (c % 8 == 0) begin
                item_t it;
                it.exp_out = x;
                it.inp     = pl(x);
                sb_q.push_back(it);
            end
            @(negedge clock_i);
        end
        start_i = 1'b0;
        repeat (10) @(negedge clock_i);
        chk("held_busy_cycles", 320'(busy_cnt), 320'd18);
        chk("held_valid_count", 320'(nvalid - v0), 320'd3);

        // Reset during the third RUN cycle aborts the inversion.
        v0 = nvalid;
        @(negedge clock_i);
        start_i  = 1'b1;
        pl_inv_i = pl(rand_state());
        @(posedge clock_i); #1;
        start_i = 1'b0;
        @(posedge clock_i);
        @(posedge clock_i);
        @(negedge clock_i);
        chk("pre_abort_busy", 320'(busy_o), 320'd1);
        reset_i = 1'b1;
        @(posedge clock_i); #1;
        chk("abort_out", pl_inv_o, 320'd0);
        chk("abort_busy", 320'(busy_o), 320'd0);
        chk("abort_valid", 320'(valid_o), 320'd0);
        @(negedge clock_i);
        reset_i = 1'b0;
        repeat (10) @(negedge clock_i);
        chk("abort_no_valid", 320'(nvalid - v0), 320'd0);

        x = rand_state();
        run_one(x, pl(x));

        repeat (3) @(negedge clock_i);
        chk("scoreboard_empty", 320'(sb_q.size()), 320'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
